// File: rtl/store_buf_pkg.sv
// -----------------------------------------------------------------------------
// store_buf_pkg
// Shared definitions for the store buffer that sits in front of the data
// memory (dm): instruction field ranges, the store opcodes dm decodes, the
// word-address slice used for dm indexing, and the buffered entry layout.
// Optional feature macro used by the design: STORE_BUF_FWD_EN.
// -----------------------------------------------------------------------------
package store_buf_pkg;

   // Opcode field of the instruction word.
   localparam int OP_HI = 31;
   localparam int OP_LO = 26;

   // Store opcodes, identical to the ones dm uses to build byte enables.
   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;

   // dm is word indexed by addr[13:2]; hits are detected at that granularity.
   localparam int WA_HI = 13;
   localparam int WA_LO = 2;
   localparam int WA_W  = WA_HI - WA_LO + 1;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] pc8;
   } sb_entry_t;

   // A buffered store can supply a whole load word only if it is an aligned sw.
   function automatic logic is_full_word_sw(input sb_entry_t e);
      return (e.ir[OP_HI:OP_LO] == OP_SW) && (e.addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/store_buf_if.sv
// -----------------------------------------------------------------------------
// store_buf_if
// Bundles the MEM-stage store request, the MEM-stage load probe, the dm write
// port and the occupancy/forwarding outputs of the store buffer.
//   master : pipeline side (drives st_*, ld_valid/ld_addr)
//   slave  : store buffer side (drives st_ready, ld_hit, dm_*, count, ld_fwd_*)
// Handshake: a store transfers on a rising clk edge where st_valid and
// st_ready are both high; st_ready depends only on buffer occupancy, never on
// st_valid, and the pipeline holds the store stable while st_ready is low.
// -----------------------------------------------------------------------------
interface store_buf_if #(
   parameter int PTRW = 2
);
   logic            st_valid;
   logic [31:0]     st_IR;
   logic [31:0]     st_addr;
   logic [31:0]     st_din;
   logic [31:0]     st_PC8;
   logic            st_ready;

   logic            ld_valid;
   logic [31:0]     ld_addr;
   logic            ld_hit;
   logic            ld_fwd_valid;
   logic [31:0]     ld_fwd_data;

   logic            dm_MemWrite;
   logic [31:0]     dm_IR;
   logic [31:0]     dm_addr;
   logic [31:0]     dm_din;
   logic [31:0]     dm_PC8;

   logic [PTRW:0]   count;

   modport master (
      output st_valid, st_IR, st_addr, st_din, st_PC8, ld_valid, ld_addr,
      input  st_ready, ld_hit, ld_fwd_valid, ld_fwd_data,
             dm_MemWrite, dm_IR, dm_addr, dm_din, dm_PC8, count
   );

   modport slave (
      input  st_valid, st_IR, st_addr, st_din, st_PC8, ld_valid, ld_addr,
      output st_ready, ld_hit, ld_fwd_valid, ld_fwd_data,
             dm_MemWrite, dm_IR, dm_addr, dm_din, dm_PC8, count
   );
endinterface

// File: rtl/store_buf_cam.sv
// -----------------------------------------------------------------------------
// store_buf_cam
// Combinational word-address matcher over the buffer entries.
//   wa_i     : word address (addr[13:2]) of every entry
//   valid_i  : which entries currently hold a pending store
//   hp_i     : head pointer, i.e. the oldest entry
//   ld_wa_i  : word address of the probing load
//   hit_o    : at least one valid entry matches
//   idx_o    : index of the youngest matching entry (hp_i when no hit)
// -----------------------------------------------------------------------------
module store_buf_cam
   import store_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic [DEPTH-1:0][WA_W-1:0] wa_i,
   input  logic [DEPTH-1:0]           valid_i,
   input  logic [PTRW-1:0]            hp_i,
   input  logic [WA_W-1:0]            ld_wa_i,
   output logic                       hit_o,
   output logic [PTRW-1:0]            idx_o
);

   logic [PTRW-1:0] age;
   logic [PTRW-1:0] best_age;

   // Age is the distance from the head; the largest matching age is the
   // youngest store, which is the one whose data a load must observe.
   always_comb begin
      hit_o    = 1'b0;
      idx_o    = hp_i;
      age      = '0;
      best_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age = PTRW'(i) - hp_i;
         if (valid_i[i] && (wa_i[i] == ld_wa_i) && (!hit_o || (age > best_age))) begin
            hit_o    = 1'b1;
            idx_o    = PTRW'(i);
            best_age = age;
         end
      end
   end

endmodule

// File: rtl/store_buf.sv
// -----------------------------------------------------------------------------
// store_buf
// In-order store FIFO between the MEM stage and dm. Stores are queued on the
// st_* handshake and drained one per cycle whenever the dm port is not taken
// by a load. A load whose word matches a pending store gets ld_hit so MEM
// stalls until that store has been written.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high, clears every pending store at once
//   bus   : store_buf_if.slave (store request, load probe, dm port, count)
// Optional feature STORE_BUF_FWD_EN: when the youngest matching entry is an
// aligned sw, its data is forwarded on ld_fwd_data and no stall is raised.
// -----------------------------------------------------------------------------
module store_buf
   import store_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic         clk,
   input  logic         reset,
   store_buf_if.slave   bus
);

   sb_entry_t             mem_q [DEPTH];
   logic [PTRW-1:0]       hp_q, hp_d;
   logic [PTRW-1:0]       tp_q, tp_d;
   logic [PTRW:0]         cnt_q, cnt_d;

   logic                  enq;
   logic                  drain;
   logic                  cam_hit;
   logic [PTRW-1:0]       cam_idx;
   logic [DEPTH-1:0]      valid_mask;
   logic [DEPTH-1:0][WA_W-1:0] entry_wa;
   logic [PTRW-1:0]       age;

   // Full is decided on the registered count only, so a full buffer refuses
   // a store even in a cycle where the head drains.
   assign bus.st_ready = (cnt_q != (PTRW+1)'(DEPTH));
   assign enq          = bus.st_valid & bus.st_ready;

   // An entry is live when its distance from the head is below the count.
   always_comb begin
      valid_mask = '0;
      entry_wa   = '0;
      age        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age           = PTRW'(i) - hp_q;
         valid_mask[i] = ({1'b0, age} < cnt_q);
         entry_wa[i]   = mem_q[i].addr[WA_HI:WA_LO];
      end
   end

   store_buf_cam #(
      .DEPTH (DEPTH),
      .PTRW  (PTRW)
   ) u_cam (
      .wa_i    (entry_wa),
      .valid_i (valid_mask),
      .hp_i    (hp_q),
      .ld_wa_i (bus.ld_addr[WA_HI:WA_LO]),
      .hit_o   (cam_hit),
      .idx_o   (cam_idx)
   );

`ifdef STORE_BUF_FWD_EN
   logic fwd_ok;
   assign fwd_ok           = cam_hit & is_full_word_sw(mem_q[cam_idx]);
   assign bus.ld_fwd_valid = bus.ld_valid & fwd_ok;
   assign bus.ld_fwd_data  = bus.ld_fwd_valid ? mem_q[cam_idx].din : 32'h0;
   assign bus.ld_hit       = bus.ld_valid & cam_hit & ~fwd_ok;
`else
   assign bus.ld_fwd_valid = 1'b0;
   assign bus.ld_fwd_data  = 32'h0;
   assign bus.ld_hit       = bus.ld_valid & cam_hit;
`endif

   // A stalled load frees the dm port, so the conflicting store (possibly the
   // head itself) can drain and the load retries after the write lands.
   assign drain = (cnt_q != '0) & (~bus.ld_valid | bus.ld_hit);

   assign bus.dm_MemWrite = drain;
   assign bus.dm_IR       = mem_q[hp_q].ir;
   assign bus.dm_addr     = mem_q[hp_q].addr;
   assign bus.dm_din      = mem_q[hp_q].din;
   assign bus.dm_PC8      = mem_q[hp_q].pc8;
   assign bus.count       = cnt_q;

   always_comb begin
      hp_d  = drain ? hp_q + 1'b1 : hp_q;
      tp_d  = enq   ? tp_q + 1'b1 : tp_q;
      cnt_d = cnt_q;
      case ({enq, drain})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hp_q  <= '0;
         tp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         hp_q  <= hp_d;
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         if (enq) begin
            mem_q[tp_q] <= '{ir: bus.st_IR, addr: bus.st_addr,
                             din: bus.st_din, pc8: bus.st_PC8};
         end
      end
   end

endmodule

// File: tb/tb_store_buf.sv
// -----------------------------------------------------------------------------
// tb_store_buf
// Directed bench for store_buf: reset state, single store latency, fill with
// blocked port and ordered drain, load hit on a byte store, simultaneous
// enqueue/drain across pointer wrap, asynchronous reset mid-cycle, and the
// STORE_BUF_FWD_EN forwarding behaviour (or its absence in the default build).
// Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_store_buf;

   localparam logic [31:0] IR_SW = 32'hAC22_0000;  // sw  $2, 0($1)
   localparam logic [31:0] IR_SB = 32'hA022_0000;  // sb  $2, 0($1)
   localparam logic [31:0] IR_SH = 32'hA422_0000;  // sh  $2, 0($1)
   localparam logic [31:0] NOHIT = 32'h0000_1000;  // word index 0x400

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [31:0] exp_q[$];
   logic [31:0] exp_a;

   store_buf_if #(.PTRW(2)) bus ();

   store_buf #(.DEPTH(4), .PTRW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_st(input logic v, input logic [31:0] ir, input logic [31:0] addr,
                           input logic [31:0] din);
      bus.st_valid = v;
      bus.st_IR    = ir;
      bus.st_addr  = addr;
      bus.st_din   = din;
      bus.st_PC8   = addr + 32'h0000_3008;
   endtask

   task automatic drive_ld(input logic v, input logic [31:0] addr);
      bus.ld_valid = v;
      bus.ld_addr  = addr;
   endtask

   // Scoreboard: whenever the DUT writes dm, the address must be the oldest
   // expected store.
   task automatic chk_drain(input string tag);
      chk({tag, "_we"}, 32'(bus.dm_MemWrite), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         exp_a = exp_q.pop_front();
         chk({tag, "_addr"}, bus.dm_addr, exp_a);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive_st(1'b0, 32'h0, 32'h0, 32'h0);
      drive_ld(1'b0, 32'h0);

      // ---- reset state ----
      #1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_ready", 32'(bus.st_ready), 32'd1);
      chk("rst_we", 32'(bus.dm_MemWrite), 32'd0);
      chk("rst_hit", 32'(bus.ld_hit), 32'd0);
      chk("rst_fwdv", 32'(bus.ld_fwd_valid), 32'd0);
      chk("rst_fwdd", bus.ld_fwd_data, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // ---- single sw, one-cycle latency ----
      @(negedge clk);
      drive_st(1'b1, IR_SW, 32'h10, 32'hDEADBEEF);
      #1;
      chk("t1_we_same_cycle", 32'(bus.dm_MemWrite), 32'd0);
      chk("t1_count0", 32'(bus.count), 32'd0);
      @(negedge clk);
      drive_st(1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("t1_count1", 32'(bus.count), 32'd1);
      chk("t1_we", 32'(bus.dm_MemWrite), 32'd1);
      chk("t1_addr", bus.dm_addr, 32'h10);
      chk("t1_din", bus.dm_din, 32'hDEADBEEF);
      chk("t1_ir", bus.dm_IR, IR_SW);
      chk("t1_pc8", bus.dm_PC8, 32'h0000_3018);
      @(negedge clk);
      #1;
      chk("t1_count_end", 32'(bus.count), 32'd0);
      chk("t1_we_end", 32'(bus.dm_MemWrite), 32'd0);

      // ---- fill with port held by a non-hitting load, then ordered drain ----
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive_ld(1'b1, NOHIT);
         drive_st(1'b1, IR_SW, 32'h100 + 32'(4*k), 32'hA0 + 32'(k));
         exp_q.push_back(32'h100 + 32'(4*k));
         #1;
         chk("t2_we_blocked", 32'(bus.dm_MemWrite), 32'd0);
         chk("t2_hit", 32'(bus.ld_hit), 32'd0);
      end
      @(negedge clk);
      drive_st(1'b1, IR_SW, 32'h200, 32'hFF);      // offered to a full buffer
      #1;
      chk("t2_count_full", 32'(bus.count), 32'd4);
      chk("t2_ready_full", 32'(bus.st_ready), 32'd0);
      chk("t2_we_full", 32'(bus.dm_MemWrite), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive_st(1'b0, 32'h0, 32'h0, 32'h0);
         drive_ld(1'b0, 32'h0);
         #1;
         chk("t2_count", 32'(bus.count), 32'(4 - k));
         chk("t2_din", bus.dm_din, 32'hA0 + 32'(k));
         chk_drain("t2");
      end
      @(negedge clk);
      #1;
      chk("t2_count_end", 32'(bus.count), 32'd0);
      chk("t2_we_end", 32'(bus.dm_MemWrite), 32'd0);

      // ---- load hits a pending sb in the same word ----
      @(negedge clk);
      drive_st(1'b1, IR_SB, 32'h21, 32'h55);
      #1;
      @(negedge clk);
      drive_st(1'b0, 32'h0, 32'h0, 32'h0);
      drive_ld(1'b1, 32'h20);
      #1;
      chk("t3_hit", 32'(bus.ld_hit), 32'd1);
      chk("t3_we", 32'(bus.dm_MemWrite), 32'd1);
      chk("t3_addr", bus.dm_addr, 32'h21);
      @(negedge clk);
      #1;
      chk("t3_hit_after", 32'(bus.ld_hit), 32'd0);
      chk("t3_we_after", 32'(bus.dm_MemWrite), 32'd0);
      chk("t3_count_after", 32'(bus.count), 32'd0);

      // ---- simultaneous enqueue/drain at count 2 across pointer wrap ----
      // Pointers are at 2 here; A,B land in slots 2,3, then C,D enqueue while
      // A,B drain so the head wraps 3 -> 0.
      @(negedge clk);
      drive_ld(1'b1, NOHIT);
      drive_st(1'b1, IR_SW, 32'h400, 32'h1);
      exp_q.push_back(32'h400);
      @(negedge clk);
      drive_st(1'b1, IR_SW, 32'h404, 32'h2);
      exp_q.push_back(32'h404);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive_ld(1'b0, 32'h0);
         drive_st(1'b1, IR_SW, 32'h408 + 32'(4*k), 32'h3 + 32'(k));
         exp_q.push_back(32'h408 + 32'(4*k));
         #1;
         chk("t4_count", 32'(bus.count), 32'd2);
         chk_drain("t4");
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive_st(1'b0, 32'h0, 32'h0, 32'h0);
         #1;
         chk("t4_count_tail", 32'(bus.count), 32'(2 - k));
         chk_drain("t4_tail");
      end
      @(negedge clk);
      #1;
      chk("t4_count_end", 32'(bus.count), 32'd0);

      // ---- asynchronous reset in the middle of a drain ----
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_ld(1'b1, NOHIT);
         drive_st(1'b1, IR_SW, 32'h300 + 32'(4*k), 32'h9);
      end
      @(negedge clk);
      drive_st(1'b0, 32'h0, 32'h0, 32'h0);
      drive_ld(1'b0, 32'h0);
      #1;
      chk("t5_count_pre", 32'(bus.count), 32'd3);
      chk("t5_we_pre", 32'(bus.dm_MemWrite), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_count_rst", 32'(bus.count), 32'd0);
      chk("t5_we_rst", 32'(bus.dm_MemWrite), 32'd0);
      chk("t5_ready_rst", 32'(bus.st_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // ---- forwarding (or plain hit in the default build) ----
      @(negedge clk);
      drive_ld(1'b1, NOHIT);
      drive_st(1'b1, IR_SW, 32'h40, 32'h12345678);
      @(negedge clk);
      drive_st(1'b0, 32'h0, 32'h0, 32'h0);
      drive_ld(1'b1, 32'h40);
      #1;
`ifdef STORE_BUF_FWD_EN
      chk("t6_fwd_valid", 32'(bus.ld_fwd_valid), 32'd1);
      chk("t6_fwd_data", bus.ld_fwd_data, 32'h12345678);
      chk("t6_hit", 32'(bus.ld_hit), 32'd0);
      chk("t6_we", 32'(bus.dm_MemWrite), 32'd0);
`else
      chk("t6_fwd_valid", 32'(bus.ld_fwd_valid), 32'd0);
      chk("t6_fwd_data", bus.ld_fwd_data, 32'd0);
      chk("t6_hit", 32'(bus.ld_hit), 32'd1);
      chk("t6_we", 32'(bus.dm_MemWrite), 32'd1);
`endif
      @(negedge clk);
      drive_ld(1'b1, NOHIT);
      drive_st(1'b1, IR_SH, 32'h42, 32'hBEEF);
      @(negedge clk);
      drive_st(1'b0, 32'h0, 32'h0, 32'h0);
      drive_ld(1'b1, 32'h40);
      #1;
      chk("t6_sh_hit", 32'(bus.ld_hit), 32'd1);
      chk("t6_sh_fwd_valid", 32'(bus.ld_fwd_valid), 32'd0);
      chk("t6_sh_we", 32'(bus.dm_MemWrite), 32'd1);
      @(negedge clk);
      drive_ld(1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("t6_count_end", 32'(bus.count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buf.md
Name: store_buf

Overview:
- Store buffer directly upstream of the data memory (dm) in the pipelined MIPS core.
- Accepts sw/sb/sh requests from the MEM stage into a small in-order FIFO.
- Drains one store per cycle to dm whenever the dm port is not used by a load.
- Detects loads that hit a pending store and requests a stall, so loads never read stale words.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
PTRW, 2, pointer width, equals log2(DEPTH)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
st_valid  in  1  MEM stage presents a store this cycle
st_IR  in  32  store instruction word; opcode field [31:26] selects sw/sb/sh
st_addr  in  32  byte address of the store
st_din  in  32  store data (rt value)
st_PC8  in  32  PC+8 of the store, carried for the dm write log
st_ready  out  1  buffer can accept; the pipeline stalls a store while low
ld_valid  in  1  a load in MEM needs the dm port this cycle
ld_addr  in  32  byte address of that load
ld_hit  out  1  load word matches a pending entry; pipeline must stall MEM
dm_MemWrite  out  1  write strobe to dm
dm_IR  out  32  head entry IR to dm
dm_addr  out  32  head entry address to dm
dm_din  out  32  head entry data to dm
dm_PC8  out  32  head entry PC+8 to dm
count  out  PTRW+1  number of valid entries
ld_fwd_valid  out  1  forwarded load data valid (optional feature)
ld_fwd_data  out  32  forwarded word (optional feature)

Behaviour:
- Storage: DEPTH entries of {IR, addr, din, PC8}; head pointer hp, tail pointer tp, counter cnt.
- Reset values: hp = 0, tp = 0, cnt = 0.
- Reset outputs: st_ready = 1, dm_MemWrite = 0, ld_hit = 0, ld_fwd_valid = 0, ld_fwd_data = 0, count = 0.
- Reset during a drain discards all pending stores.
- Enqueue: occurs when st_valid & st_ready on posedge; writes entry[tp] and sets tp = tp+1, wrapping modulo DEPTH.
- st_ready = (cnt != DEPTH), combinational.
- A full buffer never accepts, even if a drain happens in the same cycle.
- Drain: dm_MemWrite = (cnt != 0) & (!ld_valid | ld_hit).
  - The dm_* data outputs always show entry[hp].
  - When dm_MemWrite is high, hp = hp+1 on posedge.
  - A load stalled by ld_hit does not occupy the port, so draining proceeds and no deadlock occurs.
- Minimum latency is one cycle: a store enqueued at edge N can drain in cycle N+1, never combinationally in the same cycle.
- Simultaneous enqueue and drain: cnt is unchanged, both pointers advance.
- Hit detection: ld_hit = ld_valid & (some valid entry has addr[13:2] == ld_addr[13:2]). The compare is word-granular, matching dm indexing.
  - The entry being drained this cycle still counts as a hit.
  - The load retries the next cycle, after the write has landed.
- Ordering is strictly FIFO; stores reach dm in program order.
- IR is passed to dm unmodified; dm derives byte enables from it.
- st_valid with a non-store opcode is a caller error; it is enqueued as-is.

Optional Feature:
- Macro STORE_BUF_FWD_EN.
- Defined:
  - If the youngest matching entry is a sw whose addr[1:0] == 0, then ld_fwd_valid = 1, ld_fwd_data = that entry's din, and ld_hit = 0 (the load completes without a stall).
  - Partial-width (sb/sh) matches still raise ld_hit.
- Undefined: ld_fwd_valid and ld_fwd_data are tied to 0; every match raises ld_hit.

Decomposition:
- Shared package/include holds the field ranges (op 31:26) and the opcode constants for sw, sb and sh, the same ones dm uses.
- One natural sub-module: store_buf_cam, a combinational word-address matcher.
  - Inputs: entry addresses, valid mask, hp, ld_addr.
  - Outputs: hit flag and youngest-match index.

Test Plan:
- Reset, then enqueue sw addr 0x10, din 0xDEADBEEF with ld_valid = 0 -> next cycle dm_MemWrite = 1, dm_addr = 0x10, dm_din = 0xDEADBEEF; count goes 1 then 0.
- With ld_valid held 1 (no hit), enqueue 4 stores -> count = 4, st_ready = 0, dm_MemWrite = 0; drop ld_valid -> four writes in order on consecutive cycles.
- Pending sb at 0x21, load at 0x20 -> ld_hit = 1 and dm_MemWrite = 1 on the same cycle; next cycle ld_hit = 0.
- Enqueue and drain in the same cycle with count = 2 -> count stays 2; hp and tp wrap 3 -> 0 correctly.
- Assert reset asynchronously mid-cycle with count = 3 -> count = 0 and dm_MemWrite = 0 immediately, before the next edge.
- With STORE_BUF_FWD_EN, pending sw 0x40 = 0x12345678 and load at 0x40 -> ld_fwd_valid = 1, ld_fwd_data = 0x12345678, ld_hit = 0; a pending sh at 0x42 instead -> ld_hit = 1.
